// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Holds the RUN/WAIT state encoding, forwarding selects and the default watchdog limit.
package hazard_ctrl_pkg;

    typedef enum logic {
        RUN  = 1'b0,
        WAIT = 1'b1
    } state_t;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam int unsigned DEFAULT_TIMEOUT = 255;

endpackage

// File: rtl/hazard_ctrl_fwd_sel.sv
// Forwarding select for one ALU source register; purely combinational.
// The EX/MEM result is younger than MEM/WB, so it wins when both match.
module fwd_sel
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] rs,
    input  logic [4:0] mem_rd,
    input  logic       mem_regwen,
    input  logic [4:0] wb_rd,
    input  logic       wb_regwen,
    output logic [1:0] sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_regwen && (mem_rd != 5'd0) && (mem_rd == rs)) begin
            sel = FWD_MEM;
        end else if (wb_regwen && (wb_rd != 5'd0) && (wb_rd == rs)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: stalls, bubble clears, operand forwarding, dmem watchdog.
// Stall/clear/forward outputs are same-cycle combinational; counters and flags are registered.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int unsigned TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_use_rs1,
    input  logic        id_use_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwen,
    input  logic        ex_is_load,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwen,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwen,
    input  logic        br_taken,
    input  logic        dmem_busy,
    output logic        pc_stall,
    output logic        ifid_stall,
    output logic        idex_stall,
    output logic        exmem_stall,
    output logic        ifid_clear,
    output logic        idex_clear,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        timeout,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count
);

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t      state_q, state_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        timeout_q, timeout_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;
    logic [31:0] flush_count_q, flush_count_d;

    logic        load_use;
    logic        flush_evt;
    logic        timeout_hit;
    logic [1:0]  fwd_a_raw, fwd_b_raw;

    fwd_sel u_fwd_a (
        .rs         (id_rs1),
        .mem_rd     (mem_rd),
        .mem_regwen (mem_regwen),
        .wb_rd      (wb_rd),
        .wb_regwen  (wb_regwen),
        .sel        (fwd_a_raw)
    );

    fwd_sel u_fwd_b (
        .rs         (id_rs2),
        .mem_rd     (mem_rd),
        .mem_regwen (mem_regwen),
        .wb_rd      (wb_rd),
        .wb_regwen  (wb_regwen),
        .sel        (fwd_b_raw)
    );

    assign load_use = ex_is_load && ex_regwen && (ex_rd != 5'd0) &&
                      ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                       (id_use_rs2 && (id_rs2 == ex_rd)));

    assign fwd_a = rst ? FWD_RF : fwd_a_raw;
    assign fwd_b = rst ? FWD_RF : fwd_b_raw;

    // Memory freeze outranks redirect, which outranks the load-use bubble.
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_stall  = 1'b0;
        exmem_stall = 1'b0;
        ifid_clear  = 1'b0;
        idex_clear  = 1'b0;
        if (!rst) begin
            if (dmem_busy) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_stall  = 1'b1;
                exmem_stall = 1'b1;
            end else if (br_taken) begin
                ifid_clear  = 1'b1;
                idex_clear  = 1'b1;
            end else if (load_use) begin
                pc_stall    = 1'b1;
                ifid_stall  = 1'b1;
                idex_clear  = 1'b1;
            end
        end
    end

    assign flush_evt   = !rst && !dmem_busy && br_taken;
    // Flag is visible in the very WAIT cycle the count reaches the limit.
    assign timeout_hit = !rst && (state_q == WAIT) && dmem_busy &&
                         (wait_cnt_q == TIMEOUT_CNT);
    assign timeout     = timeout_q | timeout_hit;

    always_comb begin
        state_d        = state_q;
        wait_cnt_d     = wait_cnt_q;
        timeout_d      = timeout_q | timeout_hit;
        stall_cycles_d = stall_cycles_q;
        flush_count_d  = flush_count_q;

        if (state_q == RUN) begin
            if (dmem_busy) begin
                state_d    = WAIT;
                wait_cnt_d = 8'd0;
            end
        end else begin
            if (!dmem_busy) begin
                state_d = RUN;
            end else if (wait_cnt_q != 8'hFF) begin
                wait_cnt_d = wait_cnt_q + 8'd1;
            end
        end

        if (pc_stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
            stall_cycles_d = stall_cycles_q + 32'd1;
        end
        if (flush_evt && (flush_count_q != 32'hFFFF_FFFF)) begin
            flush_count_d = flush_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            wait_cnt_q     <= 8'd0;
            timeout_q      <= 1'b0;
            stall_cycles_q <= 32'd0;
            flush_count_q  <= 32'd0;
        end else begin
            state_q        <= state_d;
            wait_cnt_q     <= wait_cnt_d;
            timeout_q      <= timeout_d;
            stall_cycles_q <= stall_cycles_d;
            flush_count_q  <= flush_count_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
    assign flush_count  = flush_count_q;

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter TIMEOUT, default 255: dmem_busy cycles after which timeout sets; range 1..255.
REQ-002 clk  in  1  sole clock; all state updates on posedge clk.
REQ-003 rst  in  1  reset; synchronous and active-high.
REQ-004 id_rs1, id_rs2  in  5 each  source register indices of the instruction in ID.
REQ-005 id_use_rs1, id_use_rs2  in  1 each  ID instruction actually reads that source.
REQ-006 ex_rd  in  5;  ex_regwen  in  1;  ex_is_load  in  1  destination, write enable and load flag of the instruction in EX (ID/EX register outputs).
REQ-007 mem_rd  in  5;  mem_regwen  in  1  destination and write enable from EX/MEM.
REQ-008 wb_rd  in  5;  wb_regwen  in  1  destination and write enable from MEM/WB.
REQ-009 br_taken  in  1  branch/jump in EX redirects PC this cycle.
REQ-010 dmem_busy  in  1  data memory not ready; pipeline must freeze.
REQ-011 pc_stall, ifid_stall, idex_stall, exmem_stall  out  1 each  hold enables for PC and the IF/ID, ID/EX and EX/MEM registers.
REQ-012 ifid_clear, idex_clear  out  1 each  bubble-insert clears (idex_clear drives the ID/EX register clear).
REQ-013 fwd_a, fwd_b  out  2 each  ALU operand source: 00 register file, 01 EX/MEM, 10 MEM/WB.
REQ-014 timeout  out  1  sticky dmem_busy watchdog flag.
REQ-015 stall_cycles, flush_count  out  32 each  performance counters.

Function
REQ-016 State machine: states RUN and WAIT; stall and clear outputs are combinational from state and inputs, with no added latency.
REQ-017 load_use = ex_is_load & ex_regwen & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)).
REQ-018 Priority, highest first: rst, dmem_busy, br_taken, load_use.
REQ-019 Under dmem_busy, pc_stall, ifid_stall, idex_stall and exmem_stall are all 1, and both clears are 0; other events are ignored that cycle and re-evaluated after release.
REQ-020 Under br_taken without dmem_busy, ifid_clear = idex_clear = 1 and all stalls are 0, for exactly one cycle.
REQ-021 Under load_use alone, pc_stall = ifid_stall = idex_clear = 1 and idex_stall = exmem_stall = ifid_clear = 0, for exactly one cycle.
REQ-022 br_taken together with load_use resolves as branch only; the ID instruction is squashed and no stall occurs.
REQ-023 With no event, all stall and clear outputs are 0.
REQ-024 RUN goes to WAIT on dmem_busy; WAIT returns to RUN on the first cycle dmem_busy is 0, and outputs that cycle follow RUN rules.
REQ-025 wait_cnt (8-bit) clears on entry to WAIT and increments each WAIT cycle, saturating at 255.
REQ-026 timeout sets when wait_cnt reaches TIMEOUT while dmem_busy is 1, and holds until rst.
REQ-027 fwd_a: 01 if mem_regwen & mem_rd!=0 & mem_rd==id_rs1; else 10 if wb_regwen & wb_rd!=0 & wb_rd==id_rs1; else 00. fwd_b is the same with id_rs2. EX/MEM wins on a double match.
REQ-028 stall_cycles increments on any cycle in which pc_stall is 1.
REQ-029 flush_count increments on each REQ-020 cycle.
REQ-030 Both counters saturate at 32'hFFFFFFFF and never wrap.

Reset
REQ-031 rst forces state=RUN, wait_cnt=0, timeout=0, stall_cycles=0 and flush_count=0 at the next clock edge.
REQ-032 While rst is 1, all stall and clear outputs are 0 and fwd_a = fwd_b = 00.
REQ-033 rst asserted in WAIT returns the block to RUN regardless of dmem_busy.

Structure
REQ-034 A shared package holds the state enum (RUN, WAIT), the forwarding-select constants (FWD_RF, FWD_MEM, FWD_WB) and the default TIMEOUT.
REQ-035 One sub-module, fwd_sel, is instantiated twice to compute the forwarding select for one source register.
REQ-036 All other logic stays flat in hazard_ctrl.

Verification
REQ-037 Load-use: ex_is_load=1, ex_rd=5, ex_regwen=1, id_rs1=5, id_use_rs1=1 -> one cycle of pc_stall=ifid_stall=idex_clear=1; stall_cycles goes 0->1.
REQ-038 Forwarding: mem_rd=wb_rd=7, both regwen=1, id_rs2=7 -> fwd_b=01; then drop mem_regwen -> fwd_b=10; then set rd=0 -> fwd_b=00.
REQ-039 Branch with load_use in the same cycle -> ifid_clear=idex_clear=1, pc_stall=0; flush_count goes 0->1.
REQ-040 dmem_busy held 3 cycles with br_taken=1 -> 3 cycles of all four stalls at 1 and clears at 0, then one flush cycle on release; timeout stays 0.
REQ-041 TIMEOUT=4 and dmem_busy held 6 cycles -> timeout rises on the 5th WAIT cycle and stays 1 after release until rst.
REQ-042 rst pulsed mid-WAIT with dmem_busy=1 -> next cycle state=RUN and all counters and flags are 0.
